// File: rtl/thread_issue_scheduler_if.sv
// Issue-scheduler bundle: thread requests/stalls in, per-thread resets,
// the issue slot and the per-stage thread tags out.
interface thread_issue_scheduler_if #(
  parameter int unsigned NUM_THREADS = 5,
  parameter int unsigned PIPE_DEPTH  = 5
);
  localparam int unsigned TID_W = $clog2(NUM_THREADS);

  logic [NUM_THREADS-1:0]      thread_req;
  logic [NUM_THREADS-1:0]      thread_stall;
  logic [NUM_THREADS-1:0]      rst_thread;
  logic                        issue_valid;
  logic [TID_W-1:0]            issue_tid;
  logic [PIPE_DEPTH-1:0]       stage_valid;
  logic [TID_W*PIPE_DEPTH-1:0] stage_tid;
  logic [NUM_THREADS-1:0]      busy;
  logic [15:0]                 idle_cnt;

  // Scheduler side
  modport master (
    input  thread_req, thread_stall,
    output rst_thread, issue_valid, issue_tid, stage_valid, stage_tid, busy, idle_cnt
  );

  // Core / requester side
  modport slave (
    output thread_req, thread_stall,
    input  rst_thread, issue_valid, issue_tid, stage_valid, stage_tid, busy, idle_cnt
  );
endinterface

// File: rtl/thread_issue_scheduler.sv
// Round-robin issue scheduler for the barrel core with per-thread reset release
// and stage-by-stage thread tagging. SCHED_IDLE_CNT_EN enables the idle-slot counter.
module thread_issue_scheduler #(
  parameter int unsigned NUM_THREADS = 5,
  parameter int unsigned PIPE_DEPTH  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  thread_issue_scheduler_if.master     sched_if
);

  localparam int unsigned TID_W = $clog2(NUM_THREADS);
  localparam int unsigned CNT_W = $clog2(NUM_THREADS + 1);
  localparam int unsigned STW   = TID_W * PIPE_DEPTH;

  typedef enum logic {ST_RELEASE, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       rel_cnt_q, rel_cnt_d;
  logic [NUM_THREADS-1:0] rst_thread_q, rst_thread_d;
  logic [TID_W-1:0]       ptr_q, ptr_d;
  logic [NUM_THREADS-1:0] busy_q, busy_d;
  logic [PIPE_DEPTH-1:0]  stage_valid_q, stage_valid_d;
  logic [STW-1:0]         stage_tid_q, stage_tid_d;

  logic [TID_W-1:0]       retire_tid;
  logic [NUM_THREADS-1:0] retire_mask;
  logic [NUM_THREADS-1:0] busy_eff;
  logic [NUM_THREADS-1:0] eligible;
  logic [TID_W-1:0]       cand;
  logic                   grant;
  logic [TID_W-1:0]       win_tid;

  // Retiring thread is free for the decision made on the same edge
  assign retire_tid  = stage_tid_q[(PIPE_DEPTH-1)*TID_W +: TID_W];
  assign retire_mask = stage_valid_q[PIPE_DEPTH-1] ? (NUM_THREADS'(1) << retire_tid)
                                                   : '0;
  assign busy_eff    = busy_q & ~retire_mask;
  assign eligible    = sched_if.thread_req & ~sched_if.thread_stall
                     & ~rst_thread_q & ~busy_eff;

  always_comb begin
    state_d       = state_q;
    rel_cnt_d     = rel_cnt_q;
    rst_thread_d  = rst_thread_q;
    ptr_d         = ptr_q;
    grant         = 1'b0;
    win_tid       = '0;
    cand          = ptr_q;

    // Release one context per edge, lowest index first
    case (state_q)
      ST_RELEASE: begin
        rst_thread_d = rst_thread_q & ~(NUM_THREADS'(1) << rel_cnt_q);
        rel_cnt_d    = rel_cnt_q + CNT_W'(1);
        if (rel_cnt_q == CNT_W'(NUM_THREADS - 1)) begin
          state_d = ST_RUN;
        end
      end
      default: ;
    endcase

    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      cand = (cand == TID_W'(NUM_THREADS - 1)) ? '0 : cand + TID_W'(1);
      if (!grant && eligible[cand]) begin
        grant   = 1'b1;
        win_tid = cand;
      end
    end

    if (grant) begin
      ptr_d = win_tid;
    end

    busy_d        = busy_eff | (grant ? (NUM_THREADS'(1) << win_tid) : '0);
    stage_valid_d = {stage_valid_q[PIPE_DEPTH-2:0], grant};
    stage_tid_d   = {stage_tid_q[STW-TID_W-1:0], win_tid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RELEASE;
      rel_cnt_q     <= '0;
      rst_thread_q  <= '1;
      ptr_q         <= TID_W'(NUM_THREADS - 1);
      busy_q        <= '0;
      stage_valid_q <= '0;
      stage_tid_q   <= '0;
    end else begin
      state_q       <= state_d;
      rel_cnt_q     <= rel_cnt_d;
      rst_thread_q  <= rst_thread_d;
      ptr_q         <= ptr_d;
      busy_q        <= busy_d;
      stage_valid_q <= stage_valid_d;
      stage_tid_q   <= stage_tid_d;
    end
  end

`ifdef SCHED_IDLE_CNT_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;

  // Saturating count of empty issue slots once all contexts are out of reset
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if ((state_q == ST_RUN) && !grant && (idle_cnt_q != 16'hFFFF)) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign sched_if.idle_cnt = idle_cnt_q;
`else
  assign sched_if.idle_cnt = 16'h0000;
`endif

  assign sched_if.rst_thread  = rst_thread_q;
  assign sched_if.issue_valid = stage_valid_q[0];
  assign sched_if.issue_tid   = stage_tid_q[TID_W-1:0];
  assign sched_if.stage_valid = stage_valid_q;
  assign sched_if.stage_tid   = stage_tid_q;
  assign sched_if.busy        = busy_q;

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// Directed bench for thread_issue_scheduler: release, rotation, single thread,
// stall skip, mid-run reset and idle-counter behaviour.
module tb_thread_issue_scheduler;

  localparam int unsigned NT = 5;
  localparam int unsigned PD = 5;

  logic clk;
  logic rst;

  int n_chk;
  int n_pass;

  thread_issue_scheduler_if #(.NUM_THREADS(NT), .PIPE_DEPTH(PD)) sif ();

  thread_issue_scheduler #(.NUM_THREADS(NT), .PIPE_DEPTH(PD)) dut (
    .clk      (clk),
    .rst      (rst),
    .sched_if (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  int stall_seq [12] = '{3, 4, 0, 2, -1, 3, 4, 0, 2, -1, 3, 4};
  int after_seq [6]  = '{0, 1, 2, 3, 4, 0};

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    sif.thread_req   = '0;
    sif.thread_stall = '0;

    tick();
    tick();
    chk("rst_thread", 32'(sif.rst_thread), 32'h1F);
    chk("rst_issue_valid", 32'(sif.issue_valid), 32'h0);
    chk("rst_stage_valid", 32'(sif.stage_valid), 32'h0);
    chk("rst_stage_tid", 32'(sif.stage_tid), 32'h0);
    chk("rst_busy", 32'(sif.busy), 32'h0);
    chk("rst_idle", 32'(sif.idle_cnt), 32'h0);

    // Release: one context per edge
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("release", 32'(sif.rst_thread), (32'h1F << k) & 32'h1F);
      chk("release_no_issue", 32'(sif.issue_valid), 32'h0);
    end

    // Full rotation
    sif.thread_req = 5'b11111;
    for (int i = 1; i <= 10; i++) begin
      int n;
      tick();
      n = (i < 5) ? i : 5;
      chk("rot_valid", 32'(sif.issue_valid), 32'h1);
      chk("rot_tid", 32'(sif.issue_tid), 32'((i - 1) % 5));
      chk("rot_busy", 32'(sif.busy), (32'h1 << n) - 32'h1);
      chk("rot_stage_valid", 32'(sif.stage_valid), (32'h1 << n) - 32'h1);
      if (i >= 5) begin
        chk("rot_stage4_tid", 32'(sif.stage_tid[4*3 +: 3]), 32'((i - 5) % 5));
      end
    end
    chk("rot_idle", 32'(sif.idle_cnt), 32'h0);

    // Single requester: thread 2 at ticks 13, 18, 23
    sif.thread_req = 5'b00100;
    for (int t = 11; t <= 25; t++) begin
      logic ev;
      tick();
      ev = (t == 13) || (t == 18) || (t == 23);
      chk("single_valid", 32'(sif.issue_valid), 32'(ev));
      if (ev) begin
        chk("single_tid", 32'(sif.issue_tid), 32'h2);
      end
    end
    chk("single_busy", 32'(sif.busy), 32'h4);
`ifdef SCHED_IDLE_CNT_EN
    chk("single_idle", 32'(sif.idle_cnt), 32'd12);
`else
    chk("single_idle", 32'(sif.idle_cnt), 32'd0);
`endif

    // Thread 1 stalled for 12 edges
    sif.thread_req   = 5'b11111;
    sif.thread_stall = 5'b00010;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (stall_seq[i] < 0) begin
        chk("stall_idle_slot", 32'(sif.issue_valid), 32'h0);
      end else begin
        chk("stall_valid", 32'(sif.issue_valid), 32'h1);
        chk("stall_tid", 32'(sif.issue_tid), 32'(stall_seq[i]));
      end
      chk("stall_busy1", 32'(sif.busy[1]), 32'h0);
    end
    sif.thread_stall = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("unstall_valid", 32'(sif.issue_valid), 32'h1);
      chk("unstall_tid", 32'(sif.issue_tid), 32'(after_seq[i]));
    end
`ifdef SCHED_IDLE_CNT_EN
    chk("stall_idle", 32'(sif.idle_cnt), 32'd14);
`else
    chk("stall_idle", 32'(sif.idle_cnt), 32'd0);
`endif

    // Mid-run reset with a full pipeline
    rst = 1'b1;
    tick();
    chk("mid_rst_stage_valid", 32'(sif.stage_valid), 32'h0);
    chk("mid_rst_busy", 32'(sif.busy), 32'h0);
    chk("mid_rst_thread", 32'(sif.rst_thread), 32'h1F);
    chk("mid_rst_issue", 32'(sif.issue_valid), 32'h0);
    chk("mid_rst_idle", 32'(sif.idle_cnt), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_rel", 32'(sif.rst_thread), 32'h1E);
    chk("post_rst_no_issue", 32'(sif.issue_valid), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_valid", 32'(sif.issue_valid), 32'h1);
      chk("post_rst_tid", 32'(sif.issue_tid), 32'(k));
    end

    // No requests: idle counter saturates or stays zero
    sif.thread_req = '0;
`ifdef SCHED_IDLE_CNT_EN
    repeat (70000) tick();
    chk("idle_sat", 32'(sif.idle_cnt), 32'hFFFF);
    repeat (3) tick();
    chk("idle_sat_hold", 32'(sif.idle_cnt), 32'hFFFF);
`else
    repeat (200) tick();
    chk("idle_off", 32'(sif.idle_cnt), 32'h0);
`endif
    chk("drain_issue", 32'(sif.issue_valid), 32'h0);
    chk("drain_busy", 32'(sif.busy), 32'h0);
    chk("drain_stage_valid", 32'(sif.stage_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/thread_issue_scheduler.md
# thread_issue_scheduler

Round-robin issue scheduler for the five-context interleaved (barrel) core. Each cycle it selects at most one hardware thread to issue into the shared pipeline and tracks every in-flight instruction's thread ID stage by stage. Downstream muxes use these tags to steer register-file ports, datapath control and memory control per stage. It also sequences per-thread reset release and replaces the fixed slot counter with eligibility-aware arbitration.

## Interface
Parameters:
- NUM_THREADS, default 5: number of hardware thread contexts.
- PIPE_DEPTH, default 5: stages from issue (stage 0) to retire (stage PIPE_DEPTH-1).
- TID_W, localparam = $clog2(NUM_THREADS) (3 at default): thread-ID width.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- thread_req  in  NUM_THREADS  thread i has an instruction ready to issue.
- thread_stall  in  NUM_THREADS  thread i is held by an external wait (e.g. memory); blocks new issue only.
- rst_thread  out  NUM_THREADS  per-context reset, registered.
- issue_valid  out  1  a thread is issued this cycle; registered.
- issue_tid  out  TID_W  ID of the issued thread; registered.
- stage_valid  out  PIPE_DEPTH  bit s = stage s holds an instruction; bit 0 mirrors issue_valid.
- stage_tid  out  TID_W*PIPE_DEPTH  thread ID of stage s, packed in slice [s*TID_W +: TID_W].
- busy  out  NUM_THREADS  thread i has an instruction in flight.
- idle_cnt  out  16  count of idle issue slots (see Configuration).

## Operation
- **Reset.** While rst=1, at each edge:
  - rst_thread becomes all ones.
  - issue_valid, stage_valid, busy and idle_cnt become 0.
  - issue_tid and stage_tid become 0.
  - The round-robin pointer becomes NUM_THREADS-1, so thread 0 is searched first.
  - The release counter becomes 0.
- **Release sequence.** On the k-th edge after rst falls (k = 1..NUM_THREADS), rst_thread[k-1] clears. Once all bits are clear, the scheduler is in RUN.
- **Eligibility.** A thread is eligible when thread_req & ~thread_stall & ~rst_thread & ~busy_eff, where busy_eff is busy with the bit of the thread in stage PIPE_DEPTH-1 cleared. This retire bypass lets a thread reissue in the cycle right after it retires.
- **Arbitration.** At each edge, scan from pointer+1, wrapping modulo NUM_THREADS, and take the first eligible thread.
  - On a grant: issue_valid=1, issue_tid=winner, pointer=winner, busy[winner] set.
  - With no eligible thread: issue_valid=0 and the pointer is unchanged.
- **Stage tracker.** At each edge, stage s+1 loads stage s (valid and tid), and stage 0 loads the new issue. The entry leaving stage PIPE_DEPTH-1 clears its thread's busy bit.
  - If that thread is reissued on the same edge, busy stays 1.
- **Stalls.** thread_stall never freezes in-flight entries; there is no global pipeline stall.
- **Invariant.** At most one in-flight instruction per thread, so no intra-thread hazards. A steady state with all threads requesting and none stalled is a perfect rotation.

## Timing
- Issue latency: thread_req/thread_stall sampled at edge t, result in issue_valid/issue_tid during cycle t→t+1.
- A thread issued in cycle c is in stage s during cycle c+s, and is eligible again for the decision that issues in cycle c+PIPE_DEPTH.
- With NUM_THREADS=PIPE_DEPTH=5 and all threads requesting, each thread issues exactly every 5 cycles and issue_valid stays 1.
- A thread released at edge k can be issued at edge k+1 at the earliest.
- rst asserted mid-operation takes effect at the next edge and discards all in-flight entries. No partial retire is reported.
- Simultaneous retire and reissue of the same thread is legal and keeps busy=1.

## Configuration
- Macro: SCHED_IDLE_CNT_EN.
- **Defined:** idle_cnt increments at each edge where the scheduler is in RUN and issue_valid becomes 0. It saturates at 16'hFFFF and is cleared only by rst.
- **Undefined:** the counter logic is removed and idle_cnt is tied to 16'h0000. The port list is identical in both builds.

## Test plan
- **Release sequence.** rst=1 for 2 cycles, then 0 → rst_thread steps 11111 → 11110 → 11100 → 11000 → 10000 → 00000 on successive edges.
- **Full rotation.** All thread_req=1, no stall → issue_tid sequence 0,1,2,3,4,0,1,… once released. stage_tid slice 4 equals stage_tid slice 0 from 4 cycles earlier. busy=11111 in steady state.
- **Single thread.** Only thread_req[2]=1 → issue_valid pulses once every 5 cycles with issue_tid=2. With the macro defined, idle_cnt rises by 4 per 5 cycles.
- **Stall skip.** All threads requesting, thread_stall[1]=1 for 12 cycles → issue order 0,2,3,4,idle,0,2,… and busy[1]=0 throughout. After the stall drops, thread 1 issues at its next pointer position.
- **Mid-run reset.** rst=1 for one cycle with 4 entries in flight → next cycle stage_valid=0, busy=0, rst_thread=11111. After release, the first issue_tid is 0.
- **Idle saturation.** thread_req=0 for 70000 cycles → idle_cnt=16'hFFFF and holds. In a build without SCHED_IDLE_CNT_EN, idle_cnt stays 0.
